cmd_fetch_unit: RTL and testbench

//  Downstream consumer of the command-side memory controller. Tracks a read pointer into the

---
 rtl/cmd_fetch_unit.sv | 89 ++++++++
 tb/tb_cmd_fetch_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_fetch_unit.sv
// Command fetch unit: follows the Command RAM fill level and fetches each new token.
// It presents the token as opcode/argument over valid/ready, and turns an RST opcode into a pointer-clear pulse.
module cmd_fetch_unit #(
    parameter int         word_size   = 16,
    parameter int         buffer_size = 1024,
    parameter logic [3:0] OP_RST      = 4'h3,
    localparam int        AW          = $clog2(buffer_size)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AW-1:0]        cmd_wr_addr,
    output logic                 cmd_rd_en,
    output logic [AW-1:0]        cmd_rd_addr,
    input  logic [word_size-1:0] cmd_rd_data,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [3:0]           instr_opcode,
    output logic [word_size-5:0] instr_arg,
    output logic [AW-1:0]        instr_index,
    output logic                 ptr_clr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_ISSUE,
        S_CLEAR
    } state_t;

    state_t               r_state;
    logic [AW-1:0]        r_rd_ptr;
    logic [word_size-1:0] r_hold_cmd;
    logic [AW-1:0]        r_hold_idx;

    logic w_empty;
    logic w_issue;

    assign w_empty = (r_rd_ptr == cmd_wr_addr);
    assign w_issue = (r_state == S_ISSUE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_rd_ptr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) r_state <= S_RD_REQ;
                end
                S_RD_REQ: begin
                    r_state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (cmd_rd_data[3:0] == OP_RST) r_state <= S_CLEAR;
                    else                            r_state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (instr_ready) begin
                        r_rd_ptr <= r_rd_ptr + AW'(1);
                        r_state  <= S_IDLE;
                    end
                end
                S_CLEAR: begin
                    r_rd_ptr <= '0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Capture registers carry no reset; every consumer is gated by state.
    always_ff @(posedge clk) begin
        if (r_state == S_RD_WAIT) begin
            r_hold_cmd <= cmd_rd_data;
            r_hold_idx <= r_rd_ptr;
        end
    end

    assign cmd_rd_en    = (r_state == S_RD_REQ);
    assign cmd_rd_addr  = r_rd_ptr;
    assign instr_valid  = w_issue;
    assign instr_opcode = w_issue ? r_hold_cmd[3:0] : '0;
    assign instr_arg    = w_issue ? r_hold_cmd[word_size-1:4] : '0;
    assign instr_index  = w_issue ? r_hold_idx : '0;
    assign ptr_clr      = (r_state == S_CLEAR);

endmodule

// File: tb/tb_cmd_fetch_unit.sv
// Directed bench for cmd_fetch_unit.
// A behavioural Command RAM with one-cycle read latency drives cmd_rd_data.
module tb_cmd_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  cmd_wr_addr;
    logic        cmd_rd_en;
    logic [9:0]  cmd_rd_addr;
    logic [15:0] cmd_rd_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  instr_opcode;
    logic [11:0] instr_arg;
    logic [9:0]  instr_index;
    logic        ptr_clr;

    logic [15:0] ram [0:1023];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cmd_rd_en) cmd_rd_data <= ram[cmd_rd_addr];
    end

    cmd_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_wr_addr  (cmd_wr_addr),
        .cmd_rd_en    (cmd_rd_en),
        .cmd_rd_addr  (cmd_rd_addr),
        .cmd_rd_data  (cmd_rd_data),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_opcode (instr_opcode),
        .instr_arg    (instr_arg),
        .instr_index  (instr_index),
        .ptr_clr      (ptr_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_rd_en"}, cmd_rd_en, 0);
        chk({tag, "_valid"}, instr_valid, 0);
        chk({tag, "_clr"}, ptr_clr, 0);
    endtask

    task automatic chk_issue(input string tag, input logic [3:0] op, input logic [11:0] arg,
                             input logic [9:0] idx);
        chk({tag, "_valid"}, instr_valid, 1);
        chk({tag, "_op"}, instr_opcode, op);
        chk({tag, "_arg"}, instr_arg, arg);
        chk({tag, "_idx"}, instr_index, idx);
    endtask

    logic [3:0]  s_op  [0:7];
    logic [11:0] s_arg [0:7];

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = {i[11:0], 4'h5};
        ram[0] = 16'h0A51;
        ram[1] = 16'h1232;
        ram[2] = 16'h0003;

        rst         = 1'b0;
        cmd_wr_addr = '0;
        instr_ready = 1'b0;
        #1;
        chk("reset_rd_en", cmd_rd_en, 0);
        chk("reset_valid", instr_valid, 0);
        chk("reset_clr", ptr_clr, 0);
        chk("reset_addr", cmd_rd_addr, 0);
        step(); step(); step();
        rst = 1'b1;
        step();
        chk_quiet("idle_empty");

        // Single fetch
        instr_ready = 1'b1;
        cmd_wr_addr = 10'd1;
        step();
        chk("single_rd_en", cmd_rd_en, 1);
        chk("single_rd_addr", cmd_rd_addr, 0);
        step();
        chk_quiet("single_wait");
        step();
        chk_issue("single", 4'h1, 12'h0A5, 10'd0);
        step();
        chk("single_done_valid", instr_valid, 0);
        chk("single_done_ptr", cmd_rd_addr, 1);
        step();
        chk_quiet("single_idle");

        // Back-pressure
        instr_ready = 1'b0;
        cmd_wr_addr = 10'd2;
        step();
        chk("bp_rd_en", cmd_rd_en, 1);
        chk("bp_rd_addr", cmd_rd_addr, 1);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            chk_issue("bp_hold", 4'h2, 12'h123, 10'd1);
            chk("bp_ptr", cmd_rd_addr, 1);
            if (i < 4) step();
        end
        instr_ready = 1'b1;
        step();
        chk("bp_done_valid", instr_valid, 0);
        chk("bp_done_ptr", cmd_rd_addr, 2);

        // RST opcode
        cmd_wr_addr = 10'd3;
        step();
        chk("rst_op_rd_addr", cmd_rd_addr, 2);
        step();
        step();
        chk("rst_op_clr", ptr_clr, 1);
        chk("rst_op_valid", instr_valid, 0);
        cmd_wr_addr = 10'd0;
        step();
        chk("rst_op_clr_once", ptr_clr, 0);
        chk("rst_op_ptr", cmd_rd_addr, 0);
        step();
        chk_quiet("rst_op_idle");
        cmd_wr_addr = 10'd1;
        step();
        chk("refetch_rd_en", cmd_rd_en, 1);
        chk("refetch_addr", cmd_rd_addr, 0);
        step();
        step();
        chk_issue("refetch", 4'h1, 12'h0A5, 10'd0);
        step();
        chk("refetch_ptr", cmd_rd_addr, 1);

        // Wrap: stream forward to 1023, then fetch 1023 and 0
        ram[2] = 16'h0025;
        cmd_wr_addr = 10'd1023;
        begin
            int k;
            k = 0;
            while (cmd_rd_addr != 10'd1023 && k < 6000) begin
                step();
                k++;
            end
            chk("wrap_reach_timeout", (k < 6000), 1);
        end
        step();
        step();
        chk_quiet("wrap_parked");
        cmd_wr_addr = 10'd1;
        step();
        chk("wrap_rd_en_hi", cmd_rd_en, 1);
        chk("wrap_addr_hi", cmd_rd_addr, 1023);
        step();
        step();
        chk_issue("wrap_hi", 4'h5, 12'h3FF, 10'd1023);
        step();
        chk("wrap_ptr0", cmd_rd_addr, 0);
        step();
        chk("wrap_rd_en_lo", cmd_rd_en, 1);
        step();
        step();
        chk_issue("wrap_lo", 4'h1, 12'h0A5, 10'd0);
        step();
        chk("wrap_ptr1", cmd_rd_addr, 1);
        step(); step(); step();
        chk_quiet("wrap_stop");
        chk("wrap_stop_ptr", cmd_rd_addr, 1);

        // Reset mid-ISSUE
        instr_ready = 1'b0;
        cmd_wr_addr = 10'd2;
        step(); step(); step();
        chk("midrst_pre_valid", instr_valid, 1);
        rst = 1'b0;
        cmd_wr_addr = 10'd0;
        #1;
        chk_quiet("midrst_async");
        chk("midrst_addr", cmd_rd_addr, 0);
        step(); step();
        rst = 1'b1;
        step(); step();
        chk_quiet("midrst_release");
        chk("midrst_ptr", cmd_rd_addr, 0);

        // Stream of 4
        ram[0] = 16'h1111; s_op[0] = 4'h1; s_arg[0] = 12'h111;
        ram[1] = 16'h2224; s_op[1] = 4'h4; s_arg[1] = 12'h222;
        ram[2] = 16'h3335; s_op[2] = 4'h5; s_arg[2] = 12'h333;
        ram[3] = 16'h4446; s_op[3] = 4'h6; s_arg[3] = 12'h444;
        for (int i = 4; i < 8; i++) begin
            s_op[i] = 4'h0;
            s_arg[i] = 12'h0;
        end
        instr_ready = 1'b1;
        cmd_wr_addr = 10'd4;
        begin
            int last;
            int cnt;
            last = -1;
            cnt = 0;
            for (int c = 0; c < 40; c++) begin
                step();
                if (instr_valid) begin
                    if (cnt < 8) begin
                        chk("stream_idx", instr_index, cnt);
                        chk("stream_op", instr_opcode, s_op[cnt]);
                        chk("stream_arg", instr_arg, s_arg[cnt]);
                    end
                    chk("stream_no_clr", ptr_clr, 0);
                    if (cnt > 0) chk("stream_gap", c - last, 4);
                    last = c;
                    cnt++;
                end
            end
            chk("stream_count", cnt, 4);
        end
        chk_quiet("stream_end");
        chk("stream_end_ptr", cmd_rd_addr, 4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
